// File: rtl/triangle_cmd_fifo_if.sv
// Handshake bundle between the triangle command source, the command FIFO
// and the rasterizer. slave = FIFO view, master = source/rasterizer view.
interface triangle_cmd_fifo_if #(
  parameter int BEAT_W = 240
);
  logic [BEAT_W-1:0]   triangle_wrdata;
  logic                triangle_push;
  logic                triangle_full;
  logic [2*BEAT_W-1:0] tri_data;
  logic [1:0]          tri_cmd;
  logic                tri_valid;
  logic                tri_ready;

  modport master (
    output triangle_wrdata, triangle_push, tri_ready,
    input  triangle_full, tri_data, tri_cmd, tri_valid
  );

  modport slave (
    input  triangle_wrdata, triangle_push, tri_ready,
    output triangle_full, tri_data, tri_cmd, tri_valid
  );
endinterface

// File: rtl/triangle_cmd_fifo.sv
// Triangle command FIFO: pairs 240-bit beats into 480-bit records, classifies
// them (TRI / EFB / EF), queues them show-ahead to the rasterizer and holds
// pops after a flush command until the rasterizer goes idle, then pulses
// draw_next. Optional macro TRI_CMD_STATS_EN enables the tri_count counter.
module triangle_cmd_fifo #(
  parameter int BEAT_W = 240,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  triangle_cmd_fifo_if.slave     bus,
  input  logic                   raster_idle,
  output logic                   draw_next,
  output logic [AW:0]            fifo_level,
  output logic [1:0]             err_sticky,
  output logic [15:0]            tri_count
);

  localparam int REC_W = 2 * BEAT_W;

  typedef enum logic [1:0] {
    CMD_TRI = 2'd0,
    CMD_EFB = 2'd1,
    CMD_EF  = 2'd2
  } cmd_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_PULSE
  } fsm_t;

  logic [REC_W+1:0]  mem [DEPTH];
  logic [REC_W+1:0]  head_q;
  logic [REC_W+1:0]  wr_rec;
  logic [BEAT_W-1:0] hold_q;
  logic              half_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW-1:0]     rd_ptr_nxt;
  logic [AW:0]       level_q;
  logic [1:0]        err_q;
  logic              draw_next_q;
  fsm_t              state_q;
  cmd_t              dec_cmd;
  logic [1:0]        head_cmd;
  logic              rsvd;
  logic              full;
  logic              pop;
  logic              second_beat;
  logic              wr_en;
  logic              ovf_drop;

  // Class decode of the held first beat, bits [7:6].
  always_comb begin
    dec_cmd = CMD_TRI;
    rsvd    = 1'b0;
    unique case (hold_q[7:6])
      2'b00:   dec_cmd = CMD_TRI;
      2'b10:   dec_cmd = CMD_EFB;
      2'b01:   dec_cmd = CMD_EF;
      default: rsvd    = 1'b1;
    endcase
  end

  assign full        = (level_q == (AW+1)'(DEPTH));
  assign head_cmd    = head_q[REC_W+1:REC_W];
  assign bus.tri_valid = (level_q != '0) && (state_q == S_RUN);
  assign pop         = bus.tri_valid && bus.tri_ready;
  assign second_beat = bus.triangle_push && half_q;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the record.
  assign wr_en       = second_beat && !rsvd && (!full || pop);
  assign ovf_drop    = second_beat && !rsvd && full && !pop;
  assign wr_rec      = {dec_cmd, hold_q, bus.triangle_wrdata};
  assign rd_ptr_nxt  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

  assign bus.triangle_full = full;
  assign bus.tri_data      = head_q[REC_W-1:0];
  assign bus.tri_cmd       = head_cmd;
  assign fifo_level        = level_q;
  assign err_sticky        = err_q;
  assign draw_next         = draw_next_q;

  // Record storage; no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_rec;
  end

  // Beat pairing, pointers, level, sticky errors and the registered head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q   <= 1'b0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      err_q    <= '0;
      head_q   <= '0;
    end else begin
      if (bus.triangle_push) half_q <= ~half_q;
      if (bus.triangle_push && !half_q) hold_q <= bus.triangle_wrdata;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q <= rd_ptr_nxt;
      if (wr_en && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !wr_en) level_q <= level_q - 1'b1;
      if (ovf_drop)            err_q[0] <= 1'b1;
      if (second_beat && rsvd) err_q[1] <= 1'b1;
      // Head register follows the next read pointer; a write landing on that
      // slot this edge is forwarded so show-ahead adds no latency.
      if (wr_en && (wr_ptr_q == rd_ptr_nxt)) head_q <= wr_rec;
      else                                    head_q <= mem[rd_ptr_nxt];
    end
  end

  // Flush barrier: after an EFB/EF pop, hold pops until the rasterizer idles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      draw_next_q <= 1'b0;
    end else begin
      draw_next_q <= 1'b0;
      case (state_q)
        S_RUN:   if (pop && (head_cmd != CMD_TRI)) state_q <= S_WAIT;
        S_WAIT:  if (raster_idle) begin
                   state_q     <= S_PULSE;
                   draw_next_q <= 1'b1;
                 end
        S_PULSE: state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
    end
  end

`ifdef TRI_CMD_STATS_EN
  logic [15:0] cnt_q;

  // TRI pop counter, saturating; an EF pop restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        cnt_q <= '0;
    else if (pop && (head_cmd == CMD_EF))              cnt_q <= '0;
    else if (pop && (head_cmd == CMD_TRI) && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign tri_count = cnt_q;
`else
  assign tri_count = '0;
`endif

endmodule
